muldiv_unit: RTL and testbench

Iterative shift-add multiplier and restoring divider producing MIPS-style HI/LO results. Replaces the 32-bit unsigned multiply-only unit with a WIDTH-parametrised block that supports signed and unsigned multiply and divide. It owns its own adder instead of borrowing the processor ALU. It sits beside the execute stage: it is launched by a start pulse, and the pipeline stalls while busy is high.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_if.sv | 14 +
 rtl/muldiv_addsub.sv | 11 +
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-counter width helper.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Launch/result bundle between the execute stage and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_addsub.sv
// N-bit adder/subtractor: sum = sub ? x - y : x + y (modulo 2^N).
module muldiv_addsub #(parameter int N = 33) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum
);

  assign sum = x + (y ^ {N{sub}}) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO results.
// Divide path present only when MULDIV_DIV_EN is defined; otherwise ops 10/11 return zero.
module muldiv_unit
  import muldiv_pkg::*;
#(parameter int WIDTH = 32)
(
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for start; done pulses here for one cycle after FIX
  // PREP  | take operand magnitudes, record signs, load accumulator/counter
  // ITER  | one multiply or divide step per cycle, WIDTH steps
  // FIX   | sign correction, write hi/lo, raise done
  localparam int CW = clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, mag_b_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] acc_q, acc_iter;
  logic               neg_q, done_q;
`ifdef MULDIV_DIV_EN
  logic               neg_rem_q;
`endif

  logic               is_div, sign_a, sign_b;
  logic [WIDTH:0]     step_x, step_y, step_sum;
  logic               step_sub;
  logic [WIDTH-1:0]   neg_a_in, neg_b_in, neg_a_out, neg_b_out;
  logic [2*WIDTH-1:0] neg_p;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign is_div = op_q[1];
  assign sign_a = op_q[0] & a_q[WIDTH-1];
  assign sign_b = op_q[0] & b_q[WIDTH-1];

  // The two W-bit negators serve the operands in PREP and remainder/quotient in FIX.
`ifdef MULDIV_DIV_EN
  assign neg_a_in = (state_q == FIX) ? acc_q[2*WIDTH-1:WIDTH] : a_q;
  assign neg_b_in = (state_q == FIX) ? acc_q[WIDTH-1:0] : b_q;
`else
  assign neg_a_in = a_q;
  assign neg_b_in = b_q;
`endif

  muldiv_addsub #(.N(WIDTH+1)) u_step (
    .x(step_x), .y(step_y), .sub(step_sub), .sum(step_sum)
  );
  muldiv_addsub #(.N(WIDTH)) u_neg_a (
    .x('0), .y(neg_a_in), .sub(1'b1), .sum(neg_a_out)
  );
  muldiv_addsub #(.N(WIDTH)) u_neg_b (
    .x('0), .y(neg_b_in), .sub(1'b1), .sum(neg_b_out)
  );
  muldiv_addsub #(.N(2*WIDTH)) u_neg_p (
    .x('0), .y(acc_q), .sub(1'b1), .sum(neg_p)
  );

  always_comb begin
    step_x   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    step_y   = acc_q[0] ? {1'b0, mag_b_q} : '0;
    step_sub = 1'b0;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      step_x   = acc_q[2*WIDTH-1:WIDTH-1];
      step_y   = {1'b0, mag_b_q};
      step_sub = 1'b1;
    end
`endif
  end

  always_comb begin
    acc_iter = {step_sum, acc_q[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (is_div)
      acc_iter = step_sum[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {step_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`else
    if (is_div)
      acc_iter = acc_q;
`endif
  end

  always_comb begin
    fix_hi = neg_q ? neg_p[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fix_lo = neg_q ? neg_p[WIDTH-1:0] : acc_q[WIDTH-1:0];
    if (is_div) begin
`ifdef MULDIV_DIV_EN
      if (b_q == '0) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else begin
        fix_hi = neg_rem_q ? neg_a_out : acc_q[2*WIDTH-1:WIDTH];
        fix_lo = neg_q ? neg_b_out : acc_q[WIDTH-1:0];
      end
`else
      fix_hi = '0;
      fix_lo = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREP;
      PREP:    state_d = ITER;
      ITER:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
          end
        end
        PREP: begin
          acc_q     <= {{WIDTH{1'b0}}, (sign_a ? neg_a_out : a_q)};
          mag_b_q   <= sign_b ? neg_b_out : b_q;
          cnt_q     <= CW'(WIDTH - 1);
          neg_q     <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
          neg_rem_q <= sign_a;
`endif
        end
        ITER: begin
          acc_q <= acc_iter;
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (WIDTH=32); divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;
  bit   div_en;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Drives start so that the next rising edge is E0, then drops it.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) begin
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  function automatic logic [63:0] expect_res(input vec_t v);
    if (v.op[1] && !div_en) return 64'd0;
    return {v.hi, v.lo};
  endfunction

  vec_t vecs[13];

  initial begin
    int  n;
    int  n0;
    bit  bok;
    int  done_seen;
    vec_t v;

`ifdef MULDIV_DIV_EN
    div_en = 1'b1;
`else
    div_en = 1'b0;
`endif
    total  = 0;
    passed = 0;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[6]  = '{OP_MULTU, 32'd6,        32'd7,        32'd0,        32'd42};
    vecs[7]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
    vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[11] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(n, bok);
      chk($sformatf("vec%0d_hilo", i), {bus.hi, bus.lo}, expect_res(vecs[i]));
      chk($sformatf("vec%0d_latency", i), 64'(n), 64'd34);
      chk($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
    end

    // start mid-operation must not disturb the latched operands
    @(negedge clk);
    launch(OP_MULT, 32'hFFFFFFFD, 32'd5);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n0 = 6;
    wait_done(n, bok);
    chk("ignore_start_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
    chk("ignore_start_latency", 64'(n0 + n), 64'd34);

    // back-to-back launch in the done cycle
    @(negedge clk);
    launch(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n, bok);
    v = '{OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
    chk("b2b_first_hilo", {bus.hi, bus.lo}, expect_res(v));
    chk("b2b_done_not_busy", 64'(bus.busy), 64'd0);
    launch(OP_DIVU, 32'd100, 32'd7);
    chk("b2b_done_one_cycle", 64'(bus.done), 64'd0);
    chk("b2b_accepted_busy", 64'(bus.busy), 64'd1);
    chk("b2b_hold_hilo", {bus.hi, bus.lo}, expect_res(v));
    wait_done(n, bok);
    v = '{OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
    chk("b2b_second_hilo", {bus.hi, bus.lo}, expect_res(v));
    chk("b2b_second_latency", 64'(n), 64'd34);

    // reset during the 10th ITER cycle (E11 samples rst_n low)
    @(negedge clk);
    launch(OP_MULT, 32'hFFFFFFFD, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk("rst_mid_done", 64'(bus.done), 64'd0);
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    chk("rst_mid_no_done", 64'(done_seen), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
